irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- 8-source interrupt controller placed between peripheral interrupt outputs (the int_out/int_ack pairs of interrupt-on-change input ports, timers, etc.) and the processor's single interrupt/interrupt_ack pair.
- Masks sources and selects one pending source by priority when the CPU acknowledges.
- Returns a one-cycle acknowledge to that source and exposes its ID on a readable I/O port.
- Holds off further interrupts until the ISR writes end-of-interrupt (EOI).

Parameters:
- EN_ADDR, 8'h10, I/O address of the enable-mask register (read/write).
- ID_ADDR, 8'h11, I/O address of the source-ID register. A read returns the ID; any write is the EOI.
- PEND_ADDR, 8'h12, I/O address of the read-only pending view.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- address  in  8  CPU port address
- value_in  in  8  CPU write data
- wen  in  1  CPU write strobe
- ren  in  1  CPU read strobe
- port_out  out  8  registered read data, to CPU input mux
- irq_in  in  8  level interrupt requests; each is held by its source until acknowledged
- irq_ack  out  8  one-hot, one-cycle acknowledge back to the selected source
- cpu_int  out  1  interrupt request to CPU
- cpu_int_ack  in  1  CPU interrupt-acknowledge pulse

Behaviour:
- Reset values:
  - enable = 0, id_reg = 0, port_out = 0, irq_ack = 0, cpu_int = 0.
  - State = IDLE; rr_ptr = 0 (round-robin option only).
- Enable register: written with value_in when wen && address == EN_ADDR. The new value is visible from the next cycle.
- Pending: pending = irq_in & enable, combinational from the registered enable.
  - A mask write and a pending change in the same cycle: the FSM sees the old mask.
- Reads are registered. On ren, port_out loads:
  - enable when address == EN_ADDR;
  - id_reg when address == ID_ADDR;
  - raw irq_in when address == PEND_ADDR.
  - port_out holds its value on any other address or when ren is low.
- FSM:
  - IDLE:
    - If pending != 0: cpu_int <= 1, go to ASSERT. cpu_int is high one cycle after pending is seen.
    - cpu_int_ack in IDLE is ignored.
  - ASSERT:
    - If cpu_int_ack: select the source, cpu_int <= 0, go to SERVICE. irq_ack[sel] is high for exactly the following cycle.
    - Selection is lowest set index of pending (bit 0 = highest priority); id_reg <= {5'b0, sel}.
    - If pending == 0 at ack (spurious): id_reg <= 8'h80, irq_ack stays 0, still go to SERVICE.
    - If pending drops to 0 without an ack: cpu_int stays asserted. The CPU will vector and be served as spurious.
  - SERVICE:
    - cpu_int = 0 regardless of pending.
    - A write to ID_ADDR (data ignored) is the EOI: go to IDLE next cycle. A new request can raise cpu_int no earlier than 2 cycles after the EOI write.
    - EOI writes in IDLE or ASSERT are ignored.
- An ID read and an EOI in the same cycle: port_out gets the current id_reg, then the EOI is applied.
- Sources must drop irq_in within 1 cycle of irq_ack. A source still high at EOI is simply re-requested.
- Reset mid-operation: all state is cleared in the same cycle. Any irq_ack pulse in flight is suppressed in the cycle after rst.

Optional Feature:
- Macro: IRQ_ROUND_ROBIN_EN.
- Defined:
  - Selection is rotating priority: search starts at index rr_ptr, wrapping 7 -> 0.
  - After a non-spurious selection of sel, rr_ptr <= (sel + 1) mod 8.
  - rr_ptr is readable in id_reg bits 6:4 (spurious ID = {1'b1, rr_ptr, 4'b0}).
- Undefined: fixed priority (bit 0 highest), no rr_ptr logic; id_reg bits 6:3 always 0.

Test Plan:
- Reset, then enable = 8'h00, irq_in = 8'h04 -> cpu_int stays 0 for 20 cycles; PEND_ADDR read returns 8'h04.
- enable = 8'hFF, irq_in = 8'h0C -> cpu_int = 1 next cycle. Pulse cpu_int_ack -> cpu_int = 0, irq_ack = 8'h04 for one cycle, ID read = 8'h02.
- Source 2 drops, source 3 still high, EOI written -> cpu_int reasserts 2 cycles after the EOI. Ack -> irq_ack = 8'h08, ID = 8'h03.
- irq_in = 8'h01 raises cpu_int, then enable written 8'h00 before the ack. Pulse cpu_int_ack -> irq_ack = 0, ID = 8'h80; after EOI, cpu_int stays 0.
- rst asserted in SERVICE with irq_ack pending -> next cycle all outputs 0, enable = 0, EOI no longer required.
- With IRQ_ROUND_ROBIN_EN defined: irq_in = 8'h03 held, serviced three times with EOI each time -> IDs 0, 1, 0. Without the macro -> IDs 0, 0, 0.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// CPU port-bus, peripheral interrupt and CPU interrupt signals of irq_ctrl.
// The master side is the CPU/peripheral environment; the slave side is the controller.
interface irq_ctrl_if;
    logic [7:0] address;
    logic [7:0] value_in;
    logic       wen;
    logic       ren;
    logic [7:0] port_out;
    logic [7:0] irq_in;
    logic [7:0] irq_ack;
    logic       cpu_int;
    logic       cpu_int_ack;

    modport master (
        output address, value_in, wen, ren, irq_in, cpu_int_ack,
        input  port_out, irq_ack, cpu_int
    );

    modport slave (
        input  address, value_in, wen, ren, irq_in, cpu_int_ack,
        output port_out, irq_ack, cpu_int
    );
endinterface

// File: rtl/irq_ctrl.sv
// 8-source masked interrupt controller with ack-time selection and EOI hold-off.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; default is fixed priority (bit 0 highest).
module irq_ctrl #(
    parameter logic [7:0] EN_ADDR   = 8'h10,
    parameter logic [7:0] ID_ADDR   = 8'h11,
    parameter logic [7:0] PEND_ADDR = 8'h12
) (
    input  logic       clk,
    input  logic       rst,
    irq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t     state, state_nx;
    logic [7:0] enable, id_reg, id_nx;
    logic [7:0] irq_ack_q, ack_nx;
    logic [7:0] port_out_q;
    logic       cpu_int_q, cpu_int_nx;
    logic [7:0] pending;
    logic [2:0] sel;
    logic       found;
    logic       eoi;

    assign pending = bus.irq_in & enable;
    assign eoi     = bus.wen && (bus.address == ID_ADDR);

    assign bus.port_out = port_out_q;
    assign bus.irq_ack  = irq_ack_q;
    assign bus.cpu_int  = cpu_int_q;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [2:0] rr_ptr, rr_nx;

    // Scan from the far end so the candidate closest to rr_ptr wins.
    always_comb begin
        logic [2:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = rr_ptr + 3'(k);
            if (pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                sel   = 3'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nx   = state;
        cpu_int_nx = cpu_int_q;
        ack_nx     = '0;
        id_nx      = id_reg;
`ifdef IRQ_ROUND_ROBIN_EN
        rr_nx      = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (|pending) begin
                    cpu_int_nx = 1'b1;
                    state_nx   = ASSERT;
                end
            end
            ASSERT: begin
                // Once raised, the request is held until acked; a vanished source is served as spurious.
                if (bus.cpu_int_ack) begin
                    cpu_int_nx = 1'b0;
                    state_nx   = SERVICE;
                    if (found) begin
                        ack_nx = 8'd1 << sel;
`ifdef IRQ_ROUND_ROBIN_EN
                        rr_nx  = sel + 3'd1;
                        id_nx  = {1'b0, sel + 3'd1, 1'b0, sel};
`else
                        id_nx  = {5'b0, sel};
`endif
                    end else begin
`ifdef IRQ_ROUND_ROBIN_EN
                        id_nx  = {1'b1, rr_ptr, 4'b0};
`else
                        id_nx  = 8'h80;
`endif
                    end
                end
            end
            SERVICE: begin
                cpu_int_nx = 1'b0;
                if (eoi) state_nx = IDLE;
            end
            default: begin
                cpu_int_nx = 1'b0;
                state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            enable     <= '0;
            id_reg     <= '0;
            irq_ack_q  <= '0;
            cpu_int_q  <= 1'b0;
            port_out_q <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_ptr     <= '0;
`endif
        end else begin
            state     <= state_nx;
            id_reg    <= id_nx;
            irq_ack_q <= ack_nx;
            cpu_int_q <= cpu_int_nx;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_ptr    <= rr_nx;
`endif
            if (bus.wen && bus.address == EN_ADDR) enable <= bus.value_in;
            // Reads sample pre-edge state, so an ID read alongside EOI returns the live ID.
            if (bus.ren) begin
                case (bus.address)
                    EN_ADDR:   port_out_q <= enable;
                    ID_ADDR:   port_out_q <= id_reg;
                    PEND_ADDR: port_out_q <= bus.irq_in;
                    default:   port_out_q <= port_out_q;
                endcase
            end
        end
    end
endmodule
